bcd_digit_entry: RTL

Front-panel digit-entry block: turns three raw push-buttons (up, down, ok) into a debounced, wrap-around BCD digit 0–9 and commits it to downstream logic over a valid/ready handshake. Its live digit output drives the 4-bit `bNum` input of the 7-segment display path, so the user sees the digit while editing. It is the producer side of the digit interface whose consumer is the display decoder.

---
 rtl/bcd_digit_entry_pkg.sv | 19 +
 rtl/bcd_digit_entry_button_debouncer.sv | 52 +++++
 rtl/bcd_digit_entry.sv | 75 +++++++
 3 files changed

// File: rtl/bcd_digit_entry_pkg.sv
// Shared constants and digit helpers for the front-panel BCD digit-entry block.
package bcd_digit_entry_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t     DIGIT_MAX  = 4'd9;
  localparam logic [0:0] ST_EDIT    = 1'b0;
  localparam logic [0:0] ST_COMMIT  = 1'b1;
  localparam int         DBNC_CNT_W = 8;

  function automatic digit_t digit_inc(input digit_t d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic digit_t digit_dec(input digit_t d);
    return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_button_debouncer.sv
// One push-button path: 2-flop synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press.
module button_debouncer
  import bcd_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pressPulse
);

  localparam logic [DBNC_CNT_W:0] LP_TARGET = DEBOUNCE_CYCLES[DBNC_CNT_W:0];

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_level;
  logic                  r_pulse;
  logic [DBNC_CNT_W-1:0] r_cnt;
  logic [DBNC_CNT_W:0]   w_cnt_next;
  logic                  w_flip;

  // The extra counter bit keeps the compare exact even at DEBOUNCE_CYCLES=255.
  assign w_cnt_next = {1'b0, r_cnt} + 9'd1;
  assign w_flip     = (r_sync2 != r_level) && (w_cnt_next == LP_TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level || w_flip)
        r_cnt <= '0;
      else
        r_cnt <= w_cnt_next[DBNC_CNT_W-1:0];
      if (w_flip)
        r_level <= ~r_level;
      r_pulse <= w_flip & ~r_level;
    end
  end

  assign level      = r_level;
  assign pressPulse = r_pulse;

endmodule

// File: rtl/bcd_digit_entry.sv
// Digit-entry FSM: edits a wrap-around BCD digit from debounced up/down presses
// and commits it on ok over a valid/ready handshake.
module bcd_digit_entry
  import bcd_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnOk,
  input  logic       digitReady,
  output logic [3:0] bNum,
  output logic [3:0] digitOut,
  output logic       digitValid,
  output logic       editing
);

  logic       w_up_pulse, w_down_pulse, w_ok_pulse;
  logic       w_up_level, w_down_level, w_ok_level;
  logic       w_unused;
  logic [0:0] r_state;
  digit_t     r_bnum;
  digit_t     r_digit_out;
  logic       r_digit_valid;
  logic       r_editing;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_up (
    .clk(clk), .rst_n(rst_n), .raw(btnUp), .level(w_up_level), .pressPulse(w_up_pulse)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_down (
    .clk(clk), .rst_n(rst_n), .raw(btnDown), .level(w_down_level), .pressPulse(w_down_pulse)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_ok (
    .clk(clk), .rst_n(rst_n), .raw(btnOk), .level(w_ok_level), .pressPulse(w_ok_pulse)
  );

  // Only the press pulses drive the FSM; the held levels are not needed here.
  assign w_unused = ^{w_up_level, w_down_level, w_ok_level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_EDIT;
      r_bnum        <= 4'd0;
      r_digit_out   <= 4'd0;
      r_digit_valid <= 1'b0;
      r_editing     <= 1'b1;
    end else if (r_state == ST_EDIT) begin
      // Ok wins over a coincident up/down so the displayed value is committed.
      if (w_ok_pulse) begin
        r_digit_out   <= r_bnum;
        r_digit_valid <= 1'b1;
        r_editing     <= 1'b0;
        r_state       <= ST_COMMIT;
      end else if (w_up_pulse && !w_down_pulse) begin
        r_bnum <= digit_inc(r_bnum);
      end else if (w_down_pulse && !w_up_pulse) begin
        r_bnum <= digit_dec(r_bnum);
      end
    end else begin
      if (r_digit_valid && digitReady) begin
        r_digit_valid <= 1'b0;
        r_editing     <= 1'b1;
        r_state       <= ST_EDIT;
      end
    end
  end

  assign bNum       = r_bnum;
  assign digitOut   = r_digit_out;
  assign digitValid = r_digit_valid;
  assign editing    = r_editing;

endmodule
